// File: rtl/iod_dly_tap_ctrl.sv
// Tap controller for one DDR4 addr/cmd IOD lane: turns absolute tap targets into
// MOVE/DIRECTION/LOAD pulses. Optional MOVE_CNT output under IOD_DLY_MOVE_CNT_EN.
module iod_dly_tap_ctrl #(
  parameter int TAP_W    = 8,
  parameter int TAP_INIT = 1,
  parameter int TAP_MAX  = 127,
  parameter int MOVE_GAP = 3
) (
  input  logic             FAB_CLK,
  input  logic             ARST,
  input  logic             REQ_VALID,
  input  logic [TAP_W-1:0] REQ_TAP,
  input  logic             REQ_LOAD,
  output logic             REQ_READY,
  output logic             DELAY_LINE_MOVE,
  output logic             DELAY_LINE_DIRECTION,
  output logic             DELAY_LINE_LOAD,
  input  logic             DELAY_LINE_OUT_OF_RANGE,
  output logic [TAP_W-1:0] CUR_TAP,
  output logic             DONE,
  output logic             ERR_CLAMP,
  output logic             ERR_OOR,
`ifdef IOD_DLY_MOVE_CNT_EN
  output logic [15:0]      MOVE_CNT,
`endif
  output logic [2:0]       DBG_STATE
);

  // Handshake: a request transfers on a rising FAB_CLK edge where REQ_VALID && REQ_READY;
  // REQ_READY is high only in IDLE and requests offered at any other time are dropped.

  localparam int CNT_W = (MOVE_GAP > 1) ? $clog2(MOVE_GAP) : 1;
  localparam logic [TAP_W-1:0] TAP_INIT_V = TAP_W'(TAP_INIT);
  localparam logic [TAP_W-1:0] TAP_MAX_V  = TAP_W'(TAP_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(MOVE_GAP - 1);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_LOAD, S_SETTLE, S_MOVE, S_GAP, S_DONE
  } state_t;

  state_t           state, state_next;
  logic             armed;
  logic             from_init;
  logic [CNT_W-1:0] cnt;
  logic [TAP_W-1:0] tgt;
  logic [TAP_W-1:0] cur;
  logic             dir;
  logic             oor_q;
  logic             err_clamp;
  logic             err_oor;
  logic             accept;
  logic [TAP_W-1:0] req_tgt;
  logic             step_ok;
  logic             cnt_last;

  assign accept   = REQ_VALID && (state == S_IDLE);
  assign req_tgt  = (REQ_TAP > TAP_MAX_V) ? TAP_MAX_V : REQ_TAP;
  assign step_ok  = dir ? (cur < TAP_MAX_V) : (cur != '0);
  assign cnt_last = (cnt == CNT_LAST);

  always_comb begin
    state_next = state;
    case (state)
      // armed keeps LOAD low while ARST is held; the pulse comes on the first cycle after release
      S_INIT:   if (armed) state_next = S_SETTLE;
      S_IDLE: begin
        if (accept) begin
          if (REQ_LOAD)            state_next = S_LOAD;
          else if (req_tgt == cur) state_next = S_DONE;
          else                     state_next = S_MOVE;
        end
      end
      S_LOAD:   state_next = S_SETTLE;
      S_SETTLE: if (cnt_last) state_next = from_init ? S_IDLE : S_DONE;
      S_MOVE:   state_next = S_GAP;
      S_GAP: begin
        if (oor_q)                             state_next = S_DONE;
        else if (cnt_last) begin
          if ((cur == tgt) || !step_ok)        state_next = S_DONE;
          else                                 state_next = S_MOVE;
        end
      end
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_INIT;
    endcase
  end

  always_ff @(posedge FAB_CLK or posedge ARST) begin
    if (ARST) begin
      state     <= S_INIT;
      armed     <= 1'b0;
      from_init <= 1'b1;
      cnt       <= '0;
      tgt       <= TAP_INIT_V;
      cur       <= TAP_INIT_V;
      dir       <= 1'b0;
      oor_q     <= 1'b0;
      err_clamp <= 1'b0;
      err_oor   <= 1'b0;
    end else begin
      state <= state_next;
      armed <= 1'b1;
      oor_q <= DELAY_LINE_OUT_OF_RANGE;
      cnt   <= ((state == S_SETTLE) || (state == S_GAP)) ? cnt + 1'b1 : '0;
      if (accept) begin
        if (REQ_LOAD) begin
          from_init <= 1'b0;
          err_clamp <= 1'b0;
          err_oor   <= 1'b0;
        end else begin
          tgt <= req_tgt;
          dir <= (req_tgt > cur);
          if (REQ_TAP > TAP_MAX_V) err_clamp <= 1'b1;
        end
      end
      case (state)
        S_LOAD: cur <= TAP_INIT_V;
        S_MOVE: cur <= dir ? cur + 1'b1 : cur - 1'b1;
        S_GAP: begin
          // the IOD refused the last step, so take it back out of the tracked tap
          if (oor_q) begin
            err_oor <= 1'b1;
            cur     <= dir ? cur - 1'b1 : cur + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef IOD_DLY_MOVE_CNT_EN
  always_ff @(posedge FAB_CLK or posedge ARST) begin
    if (ARST) begin
      MOVE_CNT <= '0;
    end else if (accept && REQ_LOAD) begin
      MOVE_CNT <= '0;
    end else if ((state == S_MOVE) && (MOVE_CNT != 16'hFFFF)) begin
      MOVE_CNT <= MOVE_CNT + 16'd1;
    end
  end
`endif

  assign REQ_READY            = (state == S_IDLE);
  assign DELAY_LINE_MOVE      = (state == S_MOVE);
  assign DELAY_LINE_DIRECTION = dir;
  assign DELAY_LINE_LOAD      = (state == S_LOAD) || ((state == S_INIT) && armed);
  assign CUR_TAP              = cur;
  assign DONE                 = (state == S_DONE);
  assign ERR_CLAMP            = err_clamp;
  assign ERR_OOR              = err_oor;
  assign DBG_STATE            = state;

endmodule

// File: tb/tb_iod_dly_tap_ctrl.sv
// Bench for iod_dly_tap_ctrl: directed and random tap requests checked against a
// tap-arithmetic reference model; MOVE_CNT checked when IOD_DLY_MOVE_CNT_EN is defined.
module tb_iod_dly_tap_ctrl;
  localparam int G       = 3;
  localparam int TAP_MAX = 127;

  logic       FAB_CLK = 1'b0;
  logic       ARST;
  logic       REQ_VALID;
  logic [7:0] REQ_TAP;
  logic       REQ_LOAD;
  logic       REQ_READY;
  logic       DELAY_LINE_MOVE;
  logic       DELAY_LINE_DIRECTION;
  logic       DELAY_LINE_LOAD;
  logic       DELAY_LINE_OUT_OF_RANGE;
  logic [7:0] CUR_TAP;
  logic       DONE;
  logic       ERR_CLAMP;
  logic       ERR_OOR;
  logic [2:0] dbg_state;
`ifdef IOD_DLY_MOVE_CNT_EN
  logic [15:0] MOVE_CNT;
`endif

  iod_dly_tap_ctrl #(.TAP_W(8), .TAP_INIT(1), .TAP_MAX(TAP_MAX), .MOVE_GAP(G)) dut (
    .FAB_CLK                 (FAB_CLK),
    .ARST                    (ARST),
    .REQ_VALID               (REQ_VALID),
    .REQ_TAP                 (REQ_TAP),
    .REQ_LOAD                (REQ_LOAD),
    .REQ_READY               (REQ_READY),
    .DELAY_LINE_MOVE         (DELAY_LINE_MOVE),
    .DELAY_LINE_DIRECTION    (DELAY_LINE_DIRECTION),
    .DELAY_LINE_LOAD         (DELAY_LINE_LOAD),
    .DELAY_LINE_OUT_OF_RANGE (DELAY_LINE_OUT_OF_RANGE),
    .CUR_TAP                 (CUR_TAP),
    .DONE                    (DONE),
    .ERR_CLAMP               (ERR_CLAMP),
    .ERR_OOR                 (ERR_OOR),
`ifdef IOD_DLY_MOVE_CNT_EN
    .MOVE_CNT                (MOVE_CNT),
`endif
    .DBG_STATE               (dbg_state)
  );

  // clock / reset
  always #5 FAB_CLK = ~FAB_CLK;

  int errors = 0;
  int checks = 0;

  // reference model state
  int m_cur;
  bit m_clamp;
  bit m_oor;
  int m_mcnt;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cur = 1; m_clamp = 0; m_oor = 0; m_mcnt = 0;
  endtask

  // Called at a negedge right after ARST is released.
  task automatic init_seq(input string tag);
    int load_cnt, load_cyc, ready_cyc, done_cnt;
    load_cnt = 0; load_cyc = 0; ready_cyc = 0; done_cnt = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge FAB_CLK);
      if (DELAY_LINE_LOAD === 1'b1) begin
        load_cnt++;
        if (load_cyc == 0) load_cyc = c;
      end
      if (REQ_READY === 1'b1 && ready_cyc == 0) ready_cyc = c;
      if (DONE === 1'b1) done_cnt++;
    end
    check({tag, "_load_pulses"}, load_cnt, 1);
    check({tag, "_load_cycle"}, load_cyc, 1);
    check({tag, "_ready_cycle"}, ready_cyc, 1 + 1 + G);
    check({tag, "_no_done"}, done_cnt, 0);
    check({tag, "_cur_tap"}, CUR_TAP, m_cur);
    check({tag, "_err_clamp"}, ERR_CLAMP, 0);
    check({tag, "_err_oor"}, ERR_OOR, 0);
  endtask

  // Issues one request and follows it to DONE. oor_after>0 raises OUT_OF_RANGE
  // in the gap following that many MOVE pulses.
  task automatic run_req(input int tap, input bit load, input int oor_after);
    int cyc, moves, bad, done_cyc, loads, waits, steps, exp_moves, exp_done, tgt;
    bit exp_dir, oor_pend;
    waits = 0;
    while (REQ_READY !== 1'b1 && waits < 50) begin
      @(negedge FAB_CLK);
      waits++;
    end
    check("ready_before_req", REQ_READY, 1);
    exp_dir = 1'b0;
    if (load) begin
      exp_moves = 0;
      exp_done  = G + 2;
      m_cur = 1; m_clamp = 0; m_oor = 0; m_mcnt = 0;
    end else begin
      tgt = (tap > TAP_MAX) ? TAP_MAX : tap;
      if (tap > TAP_MAX) m_clamp = 1;
      exp_dir = (tgt > m_cur);
      steps = exp_dir ? tgt - m_cur : m_cur - tgt;
      exp_done = steps * (G + 1) + 1;
      if (oor_after > 0) begin
        exp_moves = oor_after;
        m_cur = exp_dir ? m_cur + oor_after - 1 : m_cur - oor_after + 1;
        m_oor = 1;
      end else begin
        exp_moves = steps;
        m_cur = tgt;
      end
      m_mcnt = (m_mcnt + exp_moves > 65535) ? 65535 : m_mcnt + exp_moves;
    end
    exp_q.push_back(8'(m_cur));

    REQ_VALID = 1'b1;
    REQ_TAP   = 8'(tap);
    REQ_LOAD  = load;
    @(posedge FAB_CLK);
    cyc = 0; moves = 0; bad = 0; done_cyc = 0; loads = 0; oor_pend = 0;
    while (done_cyc == 0 && cyc < 1000) begin
      @(negedge FAB_CLK);
      cyc++;
      REQ_VALID = 1'b0;
      REQ_LOAD  = 1'b0;
      if (oor_pend) begin
        DELAY_LINE_OUT_OF_RANGE = 1'b1;
        oor_pend = 0;
      end
      if (DELAY_LINE_MOVE === 1'b1) begin
        if (cyc != 1 + moves * (G + 1)) bad++;
        if (DELAY_LINE_DIRECTION !== exp_dir) bad++;
        moves++;
        if (moves == oor_after) oor_pend = 1;
      end
      if (DELAY_LINE_LOAD === 1'b1) loads++;
      if (DONE === 1'b1) done_cyc = cyc;
    end
    DELAY_LINE_OUT_OF_RANGE = 1'b0;

    check("done_seen", (done_cyc != 0), 1);
    if (oor_after == 0) check("done_cycle", done_cyc, exp_done);
    check("move_pulses", moves, exp_moves);
    check("move_spacing_dir", bad, 0);
    check("load_pulses", loads, load);
    check("cur_tap", CUR_TAP, exp_q.pop_front());
    check("err_clamp", ERR_CLAMP, m_clamp);
    check("err_oor", ERR_OOR, m_oor);
`ifdef IOD_DLY_MOVE_CNT_EN
    check("move_cnt", MOVE_CNT, m_mcnt);
`endif
  endtask

  initial begin
    int moves, cyc, waits;
    ARST = 1'b1;
    REQ_VALID = 1'b0;
    REQ_TAP = 8'd0;
    REQ_LOAD = 1'b0;
    DELAY_LINE_OUT_OF_RANGE = 1'b0;
    model_reset();

    // reset values while ARST is held across clock edges
    #22;
    check("rst_ready", REQ_READY, 0);
    check("rst_move", DELAY_LINE_MOVE, 0);
    check("rst_load", DELAY_LINE_LOAD, 0);
    check("rst_dir", DELAY_LINE_DIRECTION, 0);
    check("rst_done", DONE, 0);
    check("rst_cur_tap", CUR_TAP, 1);
    check("rst_err_clamp", ERR_CLAMP, 0);
    check("rst_err_oor", ERR_OOR, 0);
    @(negedge FAB_CLK);
    ARST = 1'b0;
    init_seq("init");

    // directed walks and boundaries
    run_req(5, 0, 0);
    run_req(0, 0, 0);
    run_req(200, 0, 0);
    run_req(127, 0, 0);
    run_req(255, 0, 0);
    run_req(0, 1, 0);
    run_req(10, 0, 3);
    run_req(10, 0, 0);
    run_req(0, 1, 0);
    run_req(5, 0, 0);
    run_req(2, 0, 0);
    run_req(0, 1, 0);

    // random requests against the model
    for (int i = 0; i < 12; i++) begin
      run_req($urandom_range(0, 255), ($urandom_range(0, 7) == 0), 0);
    end

    // reset in the middle of a move sequence
    run_req(0, 1, 0);
    waits = 0;
    while (REQ_READY !== 1'b1 && waits < 50) begin
      @(negedge FAB_CLK);
      waits++;
    end
    REQ_VALID = 1'b1;
    REQ_TAP   = 8'd20;
    REQ_LOAD  = 1'b0;
    @(posedge FAB_CLK);
    moves = 0; cyc = 0;
    while (moves < 2 && cyc < 100) begin
      @(negedge FAB_CLK);
      cyc++;
      REQ_VALID = 1'b0;
      if (DELAY_LINE_MOVE === 1'b1) moves++;
    end
    check("mid_moves_seen", moves, 2);
    ARST = 1'b1;
    #1;
    model_reset();
    check("mid_rst_move", DELAY_LINE_MOVE, 0);
    check("mid_rst_load", DELAY_LINE_LOAD, 0);
    check("mid_rst_ready", REQ_READY, 0);
    check("mid_rst_cur_tap", CUR_TAP, m_cur);
    @(negedge FAB_CLK);
    @(negedge FAB_CLK);
    ARST = 1'b0;
    init_seq("reinit");
    run_req(4, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/iod_dly_tap_ctrl.md
Name: iod_dly_tap_ctrl

Overview:
- Upstream control stage for one DDR4 address/command IOD lane.
- Converts absolute tap-target requests from training/calibration logic into the IOD's incremental delay-line pulses: DELAY_LINE_MOVE, DELAY_LINE_DIRECTION and DELAY_LINE_LOAD.
- Tracks the current tap, enforces inter-move spacing, and reacts to DELAY_LINE_OUT_OF_RANGE.
- One instance per IOD; all logic runs in the FAB_CLK domain.

Parameters:
- TAP_W, 8, width of tap values.
- TAP_INIT, 1, tap value after a load; matches the IOD static TX delay.
- TAP_MAX, 127, highest legal tap.
- MOVE_GAP, 3, idle cycles required after each MOVE pulse (>=1).

Ports:
- FAB_CLK  in  1  fabric clock; all logic rising-edge.
- ARST  in  1  asynchronous active-high reset.
- REQ_VALID  in  1  tap request valid.
- REQ_TAP  in  TAP_W  requested absolute tap.
- REQ_LOAD  in  1  request reload of the delay line to TAP_INIT (sampled with REQ_VALID).
- REQ_READY  out  1  controller can accept a request.
- DELAY_LINE_MOVE  out  1  one-cycle move pulse to the IOD.
- DELAY_LINE_DIRECTION  out  1  1 = increment, 0 = decrement.
- DELAY_LINE_LOAD  out  1  one-cycle load pulse to the IOD.
- DELAY_LINE_OUT_OF_RANGE  in  1  IOD range flag.
- CUR_TAP  out  TAP_W  current tap.
- DONE  out  1  one-cycle completion pulse.
- ERR_CLAMP  out  1  sticky: a request exceeded TAP_MAX.
- ERR_OOR  out  1  sticky: the IOD reported out-of-range.

Behaviour:
- Reset values: all outputs 0 except CUR_TAP=TAP_INIT and REQ_READY=0. State=INIT.
- Reset is asynchronous on assertion. Deassertion is taken synchronously by FAB_CLK.
- Handshake: a request is accepted when REQ_VALID && REQ_READY on a rising edge. REQ_READY=1 only in IDLE. Requests presented while not ready are ignored; no queueing.
- INIT: pulse DELAY_LINE_LOAD for 1 cycle, then go to SETTLE. This guarantees the IOD matches CUR_TAP after reset.
- IDLE: on accept:
  - REQ_LOAD=1 -> LOAD state.
  - Else target = min(REQ_TAP, TAP_MAX). If REQ_TAP>TAP_MAX, set ERR_CLAMP.
  - target == CUR_TAP -> DONE state.
  - Otherwise -> MOVE state; DIRECTION is latched as (target > CUR_TAP).
- LOAD: DELAY_LINE_LOAD=1 for exactly 1 cycle, CUR_TAP<=TAP_INIT, then SETTLE.
- SETTLE: MOVE_GAP cycles, then DONE. INIT also passes through SETTLE, but goes to IDLE without a DONE pulse.
- MOVE: DELAY_LINE_MOVE=1 for 1 cycle. CUR_TAP updates ±1 on the same edge. Then GAP state.
- GAP: MOVE_GAP cycles with MOVE low. DIRECTION is held stable from the cycle before MOVE until the end of GAP. Exit conditions:
  - Registered OUT_OF_RANGE seen during GAP -> set ERR_OOR, undo the last step (CUR_TAP reverted), go to DONE.
  - CUR_TAP == target -> DONE.
  - Otherwise -> MOVE.
- DONE: DONE=1 for 1 cycle, then IDLE.
- Timing: move spacing is exactly MOVE_GAP+1 cycles. An N-step request completes with DONE at cycle N*(MOVE_GAP+1)+1 after acceptance.
- Boundaries:
  - CUR_TAP never leaves [0, TAP_MAX]. A decrement at 0 or increment at TAP_MAX is not issued; DONE is issued instead.
  - ERR_* flags clear only on ARST or on an accepted REQ_LOAD.
- Reset mid-operation: MOVE and LOAD drop immediately and the INIT reload repeats, so tap tracking is never lost.

Optional Feature:
- Macro IOD_DLY_MOVE_CNT_EN.
- Defined: adds output MOVE_CNT [15:0]. It counts every issued DELAY_LINE_MOVE pulse, saturates at 0xFFFF, resets to 0 on ARST and on an accepted REQ_LOAD.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Release ARST -> one LOAD pulse, CUR_TAP=1, REQ_READY=1 after 1+MOVE_GAP cycles, DONE never pulses.
- Request tap 5 from 1 (MOVE_GAP=3) -> 4 MOVE pulses 4 cycles apart, DIRECTION=1, CUR_TAP=5, DONE at cycle 17 after acceptance.
- Request tap 0 from 5 -> 5 pulses with DIRECTION=0; then request 200 -> ERR_CLAMP=1, stops at CUR_TAP=127 after 127 pulses.
- Force OUT_OF_RANGE high in the GAP after the 3rd move of a 1->10 request -> ERR_OOR=1, CUR_TAP=3, DONE, no further MOVE pulses.
- Assert ARST during the GAP of a move sequence -> MOVE=0 immediately, CUR_TAP=1, LOAD re-pulses after release.
- With IOD_DLY_MOVE_CNT_EN defined: 1->5->2 -> MOVE_CNT=7; REQ_LOAD -> MOVE_CNT=0, ERR flags cleared.
